uart_i2c_usb_sel_ctrl: RTL and testbench
========================================

// Module: uart_i2c_usb_sel_ctrl
// PURPOSE
//  Sequences changes of the shared UART/I2C/USB pin-and-register select. Drains any in-flight
//  register access, isolates the pads, holds the peripherals in reset for a guard time, then
//  switches the select and releases only the chosen block. Sits between the global config
//  register (requested select) and the shared UART/I2C/USB top.
// PARAMETERS
//  GUARD_CYC     16   cycles all pads held input and all blocks held in reset before select changes
//  RST_HOLD_CYC  8    cycles the new target stays in reset after the select changes
//  DRAIN_TO      255  max cycles to wait for an in-flight access ack before forcing the switch
// PORTS
//  app_clk          in   1  single clock for all logic
//  app_rst          in   1  synchronous, active-high reset
//  sel_req          in   2  requested select: 00 UART, 01 I2C, 10 USB, 11 illegal
//  reg_cs_in        in   1  host reg chip select, held until ack
//  reg_ack_in       in   1  muxed peripheral ack
//  reg_cs_out       out  1  gated chip select to the peripherals
//  blk_ack          out  1  one-cycle ack for host accesses refused during a switch; rdata reads 0
//  uart_i2c_usb_sel out  2  active select to the pin/rdata muxes
//  pad_hold         out  1  1 forces io_oeb=2'b11 and io_out=0 at the top
//  uart_rstn        out  1  UART reset, active low
//  i2c_rstn         out  1  I2C reset, active low
//  usb_rstn         out  1  USB reset, active low
//  switch_busy      out  1  high in every state except IDLE
//  switch_done      out  1  one-cycle pulse on the RELEASE->IDLE transition
//  sel_err          out  1  sticky; set when sel_req==11 is seen in IDLE
//  drain_to_err     out  1  sticky; set when DRAIN times out
// BEHAVIOUR
//  - Reset values: state=ISOLATE, cur_sel=00, uart_i2c_usb_sel=00, pad_hold=1, all rstn=0,
//    reg_cs_out=0, blk_ack=0, switch_busy=1, switch_done=0, sel_err=0, drain_to_err=0,
//    inflight=0, counter=GUARD_CYC-1.
//  - After reset the FSM runs ISOLATE->HOLD->RELEASE and brings UART up. Reset mid-switch
//    aborts the switch and restarts the same sequence.
//  - inflight sets on reg_cs_out&~reg_ack_in. It clears on reg_ack_in.
//  - IDLE: reg_cs_out=reg_cs_in. Only the rstn of cur_sel is 1. pad_hold=0.
//    If sel_req!=cur_sel and sel_req!=11, latch sel_tgt<=sel_req and go to DRAIN.
//    If sel_req==11, set sel_err and stay in IDLE. If sel_req==cur_sel, take no action.
//  - DRAIN: new accesses are blocked; reg_cs_out=reg_cs_in&inflight, so only the pending access
//    completes. Go to ISOLATE when inflight==0; an ack on the DRAIN entry cycle counts, so the
//    exit is the next cycle. On timeout after DRAIN_TO cycles, set drain_to_err, clear inflight,
//    and go to ISOLATE.
//  - ISOLATE: pad_hold=1, all rstn=0, reg_cs_out=0. Count GUARD_CYC cycles.
//    On the last cycle, cur_sel<=sel_tgt and go to HOLD.
//  - HOLD: the new select drives uart_i2c_usb_sel. pad_hold=1, all rstn=0.
//    Stay RST_HOLD_CYC cycles, then go to RELEASE.
//  - RELEASE (1 cycle): the cur_sel rstn goes 1 and pad_hold goes 0, both registered.
//    switch_done=1. Next state is IDLE.
//  - Blocked access, i.e. reg_cs_in high while not IDLE and not passed through:
//    blk_ack=reg_cs_in&~blk_ack_q, giving one ack per access; the host then drops cs.
//  - sel_req changes during a switch are ignored. They are re-evaluated in IDLE, so A->B->A costs
//    two full switches.
//  - Cycle budget: IDLE->IDLE with no inflight access is 1+GUARD_CYC+RST_HOLD_CYC+1 cycles.
//  - One shared down-counter serves DRAIN, ISOLATE and HOLD, reloaded on each state entry.
//    Width is $clog2(max(GUARD_CYC,RST_HOLD_CYC,DRAIN_TO)+1). All parameters must be >=1.
//  - All outputs are registered.
// STRUCTURE
//  - Package uart_i2c_usb_pkg: localparams SEL_UART=2'b00, SEL_I2C=2'b01, SEL_USB=2'b10,
//    SEL_ILL=2'b11; typedef enum sel_state_t {IDLE,DRAIN,ISOLATE,HOLD,RELEASE}.
//  - The top-level select mux reuses these constants.
//  - No sub-module; the FSM plus the shared counter are inline.
// TESTING
//  1. Reset with defaults -> pad_hold=1 and all rstn=0 for 16+8 cycles; then uart_rstn=1, sel=00,
//     switch_done pulses once, switch_busy=0.
//  2. IDLE sel 00, sel_req->01, no access -> exactly 26 cycles later switch_done pulses,
//     sel=01, i2c_rstn=1, uart_rstn=0.
//  3. Access in flight, ack 5 cycles after sel_req->10 -> reg_ack_in passes, DRAIN lasts 5
//     cycles, then ISOLATE. A second host cs during the switch gets blk_ack once, 1 cycle later.
//  4. Ack never arrives, DRAIN_TO=255 -> drain_to_err=1 after 255 DRAIN cycles; switch completes.
//  5. sel_req=11 in IDLE -> sel_err=1, select unchanged. sel_req 00->01->00 mid-switch ->
//     01 completes, then a second full switch back to 00.
//  6. app_rst asserted during HOLD of a USB switch -> sel=00, and the reset sequence restarts
//     from ISOLATE.

Source files
------------

// File: rtl/uart_i2c_usb_pkg.sv
// Select encodings, switch-sequencer states and small helpers shared by the
// UART/I2C/USB select controller and the top-level select mux.
package uart_i2c_usb_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned RSTN_W = 3;

    localparam logic [SEL_W-1:0] SEL_UART = 2'b00;
    localparam logic [SEL_W-1:0] SEL_I2C  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_USB  = 2'b10;
    localparam logic [SEL_W-1:0] SEL_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ISOLATE,
        HOLD,
        RELEASE
    } sel_state_t;

    // Released-reset vector {usb, i2c, uart}: only the selected block leaves reset.
    function automatic logic [RSTN_W-1:0] sel_rstn(input logic [SEL_W-1:0] sel);
        logic [RSTN_W-1:0] rstn;
        rstn = '0;
        case (sel)
            SEL_UART: rstn = 3'b001;
            SEL_I2C:  rstn = 3'b010;
            SEL_USB:  rstn = 3'b100;
            default:  rstn = '0;
        endcase
        return rstn;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/uart_i2c_usb_sel_ctrl.sv
// Sequences a change of the shared UART/I2C/USB select: drain the pending register
// access, isolate the pads under reset, switch the select, then release one block.
module uart_i2c_usb_sel_ctrl
    import uart_i2c_usb_pkg::*;
#(
    parameter int unsigned GUARD_CYC    = 16,
    parameter int unsigned RST_HOLD_CYC = 8,
    parameter int unsigned DRAIN_TO     = 255
) (
    input  logic       app_clk,
    input  logic       app_rst,
    input  logic [1:0] sel_req,
    input  logic       reg_cs_in,
    input  logic       reg_ack_in,
    output logic       reg_cs_out,
    output logic       blk_ack,
    output logic [1:0] uart_i2c_usb_sel,
    output logic       pad_hold,
    output logic       uart_rstn,
    output logic       i2c_rstn,
    output logic       usb_rstn,
    output logic       switch_busy,
    output logic       switch_done,
    output logic       sel_err,
    output logic       drain_to_err
);

    localparam int unsigned MAX_CYC = max3(GUARD_CYC, RST_HOLD_CYC, DRAIN_TO);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    sel_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SEL_W-1:0]  cur_sel_q;
    logic [SEL_W-1:0]  sel_tgt_q;
    logic [RSTN_W-1:0] rstn_q;
    logic              inflight_q;
    logic              reg_cs_out_q;
    logic              blk_ack_q;
    logic              pad_hold_q;
    logic              busy_q;
    logic              done_q;
    logic              sel_err_q;
    logic              drain_to_err_q;

    logic              pass_c;
    logic              inflight_c;
    logic              blocked_c;
    logic              cnt_zero_c;

    // pass_c marks the access already handed to a peripheral, including its ack cycle,
    // so the completing access is never mistaken for a new one and refused.
    always_comb begin
        pass_c     = inflight_q | reg_cs_out_q;
        inflight_c = pass_c & ~reg_ack_in;
        cnt_zero_c = (cnt_q == '0);
        blocked_c  = reg_cs_in & (state_q != IDLE) & ~((state_q == DRAIN) & pass_c);
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state_q        <= ISOLATE;
            cnt_q          <= GUARD_LOAD;
            cur_sel_q      <= SEL_UART;
            sel_tgt_q      <= SEL_UART;
            rstn_q         <= '0;
            inflight_q     <= 1'b0;
            reg_cs_out_q   <= 1'b0;
            blk_ack_q      <= 1'b0;
            pad_hold_q     <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            sel_err_q      <= 1'b0;
            drain_to_err_q <= 1'b0;
        end else begin
            inflight_q <= inflight_c;
            blk_ack_q  <= blocked_c & ~blk_ack_q;
            done_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    // cs drops on the ack cycle so the registered copy never outlives the access
                    reg_cs_out_q <= reg_cs_in & ~reg_ack_in;
                    if (sel_req == SEL_ILL) begin
                        sel_err_q <= 1'b1;
                    end else if (sel_req != cur_sel_q) begin
                        sel_tgt_q <= sel_req;
                        state_q   <= DRAIN;
                        cnt_q     <= DRAIN_LOAD;
                        busy_q    <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (!inflight_c || cnt_zero_c) begin
                        if (inflight_c) begin
                            drain_to_err_q <= 1'b1;
                            inflight_q     <= 1'b0;
                        end
                        state_q      <= ISOLATE;
                        cnt_q        <= GUARD_LOAD;
                        reg_cs_out_q <= 1'b0;
                        pad_hold_q   <= 1'b1;
                        rstn_q       <= '0;
                    end else begin
                        reg_cs_out_q <= reg_cs_in;
                        cnt_q        <= cnt_q - CNT_ONE;
                    end
                end

                ISOLATE: begin
                    reg_cs_out_q <= 1'b0;
                    if (cnt_zero_c) begin
                        cur_sel_q <= sel_tgt_q;
                        state_q   <= HOLD;
                        cnt_q     <= HOLD_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                HOLD: begin
                    reg_cs_out_q <= 1'b0;
                    if (cnt_zero_c) begin
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                RELEASE: begin
                    reg_cs_out_q <= 1'b0;
                    state_q      <= IDLE;
                    rstn_q       <= sel_rstn(cur_sel_q);
                    pad_hold_q   <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end

                default: begin
                    state_q      <= ISOLATE;
                    cnt_q        <= GUARD_LOAD;
                    reg_cs_out_q <= 1'b0;
                    pad_hold_q   <= 1'b1;
                    rstn_q       <= '0;
                    busy_q       <= 1'b1;
                end
            endcase
        end
    end

    assign reg_cs_out       = reg_cs_out_q;
    assign blk_ack          = blk_ack_q;
    assign uart_i2c_usb_sel = cur_sel_q;
    assign pad_hold         = pad_hold_q;
    assign uart_rstn        = rstn_q[0];
    assign i2c_rstn         = rstn_q[1];
    assign usb_rstn         = rstn_q[2];
    assign switch_busy      = busy_q;
    assign switch_done      = done_q;
    assign sel_err          = sel_err_q;
    assign drain_to_err     = drain_to_err_q;

endmodule

// File: tb/tb_uart_i2c_usb_sel_ctrl.sv
// Self-checking bench for uart_i2c_usb_sel_ctrl: each requested switch pushes its expected
// select, reset vector and latency; the switch_done monitor pops and compares.
module tb_uart_i2c_usb_sel_ctrl;
    import uart_i2c_usb_pkg::*;

    localparam int GUARD   = 16;
    localparam int HOLDC   = 8;
    localparam int DTO     = 255;
    localparam int SEQ_LAT = GUARD + HOLDC + 1;

    logic       app_clk = 1'b0;
    logic       app_rst = 1'b1;
    logic [1:0] sel_req = 2'b00;
    logic       reg_cs_in = 1'b0;
    logic       reg_ack_in = 1'b0;
    logic       reg_cs_out, blk_ack, pad_hold;
    logic [1:0] uart_i2c_usb_sel;
    logic       uart_rstn, i2c_rstn, usb_rstn;
    logic       switch_busy, switch_done, sel_err, drain_to_err;

    typedef struct {
        logic [1:0] sel;
        logic [2:0] rstn;
        int         t0;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   blk_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   blk0;
    int   t0_first;
    logic found;

    uart_i2c_usb_sel_ctrl #(
        .GUARD_CYC    (GUARD),
        .RST_HOLD_CYC (HOLDC),
        .DRAIN_TO     (DTO)
    ) dut (
        .app_clk          (app_clk),
        .app_rst          (app_rst),
        .sel_req          (sel_req),
        .reg_cs_in        (reg_cs_in),
        .reg_ack_in       (reg_ack_in),
        .reg_cs_out       (reg_cs_out),
        .blk_ack          (blk_ack),
        .uart_i2c_usb_sel (uart_i2c_usb_sel),
        .pad_hold         (pad_hold),
        .uart_rstn        (uart_rstn),
        .i2c_rstn         (i2c_rstn),
        .usb_rstn         (usb_rstn),
        .switch_busy      (switch_busy),
        .switch_done      (switch_done),
        .sel_err          (sel_err),
        .drain_to_err     (drain_to_err)
    );

    always #5 app_clk = ~app_clk;

    always @(posedge app_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp_v, cyc);
        end
    endtask

    // t0 is the clock edge on which the sequence began; lat counts edges up to IDLE entry.
    task automatic push_exp(input logic [1:0] sel, input int t0, input int lat);
        exp_t e;
        e.sel  = sel;
        e.rstn = 3'b001 << sel;
        e.t0   = t0;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge app_clk);
            n++;
        end
        check_eq("done_timeout", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    always @(negedge app_clk) begin
        if (!app_rst) begin
            if (blk_ack) blk_cnt++;
            if (switch_done) begin
                if (exp_q.size() == 0) begin
                    check_eq("done_unexpected", 32'(1), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("done_sel", 32'(uart_i2c_usb_sel), 32'(mon_e.sel));
                    check_eq("done_rstn", 32'({usb_rstn, i2c_rstn, uart_rstn}), 32'(mon_e.rstn));
                    check_eq("done_latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
                    check_eq("done_pads", 32'(pad_hold), 32'(0));
                    check_eq("done_busy", 32'(switch_busy), 32'(0));
                end
            end
        end
    end

    initial begin
        // 1: reset values, then the power-on sequence brings UART up
        repeat (2) @(negedge app_clk);
        check_eq("rst_pad_hold", 32'(pad_hold), 32'(1));
        check_eq("rst_rstn", 32'({usb_rstn, i2c_rstn, uart_rstn}), 32'(0));
        check_eq("rst_sel", 32'(uart_i2c_usb_sel), 32'(0));
        check_eq("rst_cs_blk", 32'({reg_cs_out, blk_ack}), 32'(0));
        check_eq("rst_busy_done", 32'({switch_busy, switch_done}), 32'(2));
        check_eq("rst_errs", 32'({sel_err, drain_to_err}), 32'(0));
        app_rst = 1'b0;
        push_exp(SEL_UART, cyc, SEQ_LAT);
        for (int i = 0; i < GUARD + HOLDC; i++) begin
            @(negedge app_clk);
            check_eq("boot_pad_hold", 32'(pad_hold), 32'(1));
            check_eq("boot_rstn", 32'({usb_rstn, i2c_rstn, uart_rstn}), 32'(0));
        end
        wait_done(10);
        check_eq("boot_idle_busy", 32'(switch_busy), 32'(0));

        // 2: plain switch UART -> I2C
        @(negedge app_clk);
        sel_req = SEL_I2C;
        push_exp(SEL_I2C, cyc + 1, SEQ_LAT + 1);
        @(negedge app_clk);
        check_eq("t2_busy", 32'(switch_busy), 32'(1));
        wait_done(60);

        // 3: access in flight drains for 5 cycles, a second access is refused once
        @(negedge app_clk);
        reg_cs_in = 1'b1;
        @(negedge app_clk);
        check_eq("t3_cs_pass", 32'(reg_cs_out), 32'(1));
        blk0 = blk_cnt;
        sel_req = SEL_USB;
        push_exp(SEL_USB, cyc + 1, SEQ_LAT + 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge app_clk);
            check_eq("t3_drain_cs", 32'(reg_cs_out), 32'(1));
            check_eq("t3_drain_pads", 32'(pad_hold), 32'(0));
        end
        reg_ack_in = 1'b1;
        @(negedge app_clk);
        reg_ack_in = 1'b0;
        reg_cs_in  = 1'b0;
        check_eq("t3_isolate_cs", 32'(reg_cs_out), 32'(0));
        check_eq("t3_isolate_pads", 32'(pad_hold), 32'(1));
        repeat (3) @(negedge app_clk);
        check_eq("t3_no_blk_for_passed", 32'(blk_cnt - blk0), 32'(0));
        reg_cs_in = 1'b1;
        @(negedge app_clk);
        check_eq("t3_blk_ack", 32'(blk_ack), 32'(1));
        check_eq("t3_blk_cs_gated", 32'(reg_cs_out), 32'(0));
        reg_cs_in = 1'b0;
        @(negedge app_clk);
        check_eq("t3_blk_single", 32'(blk_ack), 32'(0));
        check_eq("t3_blk_count", 32'(blk_cnt - blk0), 32'(1));
        wait_done(80);
        check_eq("t3_no_drain_err", 32'(drain_to_err), 32'(0));

        // 4: ack never arrives, drain times out after DRAIN_TO cycles
        @(negedge app_clk);
        reg_cs_in = 1'b1;
        @(negedge app_clk);
        sel_req = SEL_UART;
        push_exp(SEL_UART, cyc + 1, SEQ_LAT + DTO);
        repeat (DTO) @(negedge app_clk);
        check_eq("t4_err_before", 32'(drain_to_err), 32'(0));
        check_eq("t4_cs_held", 32'(reg_cs_out), 32'(1));
        @(negedge app_clk);
        check_eq("t4_err_set", 32'(drain_to_err), 32'(1));
        check_eq("t4_cs_cut", 32'(reg_cs_out), 32'(0));
        check_eq("t4_pads", 32'(pad_hold), 32'(1));
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge app_clk);
            if (blk_ack) found = 1'b1;
        end
        check_eq("t4_blk_after_to", 32'(found), 32'(1));
        reg_cs_in = 1'b0;
        wait_done(80);
        check_eq("t4_err_sticky", 32'(drain_to_err), 32'(1));

        // 5: illegal request, then A->B->A during a switch costs two switches
        @(negedge app_clk);
        sel_req = SEL_ILL;
        @(negedge app_clk);
        @(negedge app_clk);
        check_eq("t5_sel_err", 32'(sel_err), 32'(1));
        check_eq("t5_ill_sel", 32'(uart_i2c_usb_sel), 32'(SEL_UART));
        check_eq("t5_ill_busy", 32'(switch_busy), 32'(0));
        sel_req = SEL_UART;
        repeat (2) @(negedge app_clk);
        check_eq("t5_same_busy", 32'(switch_busy), 32'(0));
        sel_req  = SEL_I2C;
        t0_first = cyc + 1;
        push_exp(SEL_I2C, t0_first, SEQ_LAT + 1);
        push_exp(SEL_UART, t0_first + SEQ_LAT + 2, SEQ_LAT + 1);
        repeat (5) @(negedge app_clk);
        sel_req = SEL_UART;
        wait_done(120);
        check_eq("t5_back_sel", 32'(uart_i2c_usb_sel), 32'(SEL_UART));
        check_eq("t5_err_sticky", 32'(sel_err), 32'(1));

        // 6: reset during HOLD of a USB switch restarts the power-on sequence
        @(negedge app_clk);
        sel_req = SEL_USB;
        push_exp(SEL_USB, cyc + 1, SEQ_LAT + 1);
        repeat (20) @(negedge app_clk);
        check_eq("t6_hold_sel", 32'(uart_i2c_usb_sel), 32'(SEL_USB));
        check_eq("t6_hold_rstn", 32'({usb_rstn, i2c_rstn, uart_rstn}), 32'(0));
        exp_q.delete();
        app_rst = 1'b1;
        sel_req = SEL_UART;
        @(negedge app_clk);
        check_eq("t6_rst_sel", 32'(uart_i2c_usb_sel), 32'(SEL_UART));
        check_eq("t6_rst_pads", 32'(pad_hold), 32'(1));
        check_eq("t6_rst_errs", 32'({sel_err, drain_to_err}), 32'(0));
        check_eq("t6_rst_busy", 32'(switch_busy), 32'(1));
        @(negedge app_clk);
        app_rst = 1'b0;
        push_exp(SEL_UART, cyc, SEQ_LAT);
        wait_done(60);
        check_eq("t6_uart_up", 32'({usb_rstn, i2c_rstn, uart_rstn}), 32'(3'b001));

        repeat (3) @(negedge app_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
